// File: rtl/lieat_general_mem_rsp.sv
// ----------------------------------------------------------------------------
// lieat_general_mem_rsp
//
// Small single-ported word memory with a valid/ready request channel and a
// valid/ready response channel. Only one transaction is in flight at a time.
// Writes commit at the accept edge with per-byte enables. Reads capture the
// addressed word at the accept edge. Every request produces exactly one
// response LATENCY cycles after it is accepted. Write responses carry zero
// data and rsp_wr=1.
//
// Parameters
//   AW        word-address width; the memory holds 2^AW 32-bit words
//   LATENCY   cycles from accept to rsp_valid, legal range 1..7
//
// Ports
//   clock      single rising-edge clock
//   reset      synchronous, active-high; clears state, response and memory
//   req_valid  request present
//   req_ready  responder idle and able to accept a request
//   req_addr   word address (wraps naturally at 2^AW)
//   req_wen    1 = write, 0 = read
//   req_mask   byte enables for writes, bit3 -> [31:24] ... bit0 -> [7:0]
//   req_wdata  write data
//   rsp_valid  response present
//   rsp_ready  consumer accepts the response
//   rsp_rdata  read data (0 for write responses)
//   rsp_wr     response belongs to a write
// ----------------------------------------------------------------------------
module lieat_general_mem_rsp #(
    parameter int AW      = 4,
    parameter int LATENCY = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_wen,
    input  logic [3:0]    req_mask,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_wr
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic [31:0] mem_q [DEPTH];
    logic        accept;

    // Ready is a pure decode of the state so the upstream valid never loops
    // back into ready combinationally.
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_wr    = wr_q;

    // Next-state logic. The response register is loaded only at accept, so
    // it stays frozen through WAIT and while RESP is stalled by rsp_ready=0.
    // The counter holds the number of WAIT cycles still to go; leaving WAIT
    // happens on the edge where it reads 1.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = req_wen ? 32'd0 : mem_q[req_addr];
                    wr_d    = req_wen;
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                        count_d = 3'd0;
                    end else begin
                        state_d = WAIT;
                        count_d = 3'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (count_q == 3'd1) begin
                    state_d = RESP;
                    count_d = 3'd0;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 3'd0;
            end
        endcase
    end

    // Control and response registers. Reset wins over any handshake that
    // happens to coincide with it, which also aborts an in-flight response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            rdata_q <= 32'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
        end
    end

    // Memory array. A write commits at the accept edge lane by lane; an
    // all-zero mask still runs the transaction but touches no byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (accept && req_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (req_mask[b]) begin
                    mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/lieat_general_mem_rsp.md
LIEAT_GENERAL_MEM_RSP -- requirements
Module: lieat_general_mem_rsp

Interface
REQ-001 The block SHALL have parameter AW, default 4, meaning word-address width; depth is 2^AW 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from request accept to rsp_valid; legal range 1..7.
REQ-003 The block SHALL have port clock  input  1  meaning the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning reset, which is synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  meaning the request is present.
REQ-006 The block SHALL have port req_ready  output  1  meaning the responder can accept a request.
REQ-007 The block SHALL have port req_addr  input  AW  meaning the word address.
REQ-008 The block SHALL have port req_wen  input  1  meaning 1 = write, 0 = read.
REQ-009 The block SHALL have port req_mask  input  4  meaning byte enables; bit3 selects [31:24] and bit0 selects [7:0].
REQ-010 The block SHALL have port req_wdata  input  32  meaning the write data.
REQ-011 The block SHALL have port rsp_valid  output  1  meaning the response is present.
REQ-012 The block SHALL have port rsp_ready  input  1  meaning the consumer accepts the response.
REQ-013 The block SHALL have port rsp_rdata  output  32  meaning the read data, which is 0 for write responses.
REQ-014 The block SHALL have port rsp_wr  output  1  meaning the response belongs to a write.

Function
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP, with one transaction outstanding at most.
REQ-016 req_ready SHALL be 1 only in IDLE, decoded from the state with no combinational path from req_valid.
REQ-017 Accept SHALL occur at the edge where req_valid=1 and req_ready=1.
REQ-018 At accept, for LATENCY=1 the FSM SHALL go IDLE->RESP; otherwise it SHALL go IDLE->WAIT and load the counter with LATENCY-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go WAIT->RESP at the edge where the counter is 1.
REQ-020 rsp_valid SHALL be 1 exactly in RESP and SHALL first be high LATENCY cycles after the accept edge.
REQ-021 In RESP, the FSM SHALL go RESP->IDLE at the edge with rsp_ready=1; otherwise it SHALL hold RESP with rsp_rdata and rsp_wr stable.
REQ-022 The block SHALL have no same-cycle turnaround: req_ready rises the cycle after the response handshake, giving a peak throughput of one transaction per LATENCY+1 cycles.
REQ-023 A write SHALL commit at the accept edge, updating byte lane i only if req_mask[i]=1; req_mask=0 SHALL leave memory unchanged but still produce a response.
REQ-024 A read SHALL capture mem[req_addr] into the response register at the accept edge; req_mask SHALL be ignored for reads.
REQ-025 Request inputs SHALL be ignored outside IDLE.
REQ-026 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-027 A read following a write to the same address SHALL return the merged word.
REQ-028 Addresses SHALL wrap naturally at 2^AW, with no out-of-range condition.

Reset
REQ-029 With reset=1 at an edge, the block SHALL set state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_wr=0 and all memory words=0.
REQ-030 Reset SHALL dominate a simultaneous request or response handshake, so that no write commits and no transaction is accepted.
REQ-031 Reset in WAIT or RESP SHALL abort the transaction without producing a response.
REQ-032 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 The bench SHALL check that after reset, a read of addr 5 returns rsp_rdata=0x00000000 and rsp_wr=0, with rsp_valid rising 2 cycles after accept.
REQ-034 The bench SHALL check that a write of addr 3 with mask=4'b1111 and data=0xDEADBEEF, then a write of addr 3 with mask=4'b0101 and data=0x11223344, then a read of addr 3, returns 0xDE22BE44.
REQ-035 The bench SHALL check that a read with rsp_ready held low for 5 cycles keeps rsp_valid=1 and rsp_rdata stable with req_ready=0, and that req_ready=1 is seen the cycle after rsp_ready rises.
REQ-036 The bench SHALL check that with LATENCY=1 and LATENCY=7, rsp_valid is first high exactly 1 and 7 cycles after the accept edge.
REQ-037 The bench SHALL check that reset asserted in WAIT after a write of 0xCAFEF00D to addr 9 gives rsp_valid=0, and that a subsequent read of addr 9 returns 0x00000000.
REQ-038 The bench SHALL check that with AW=4, a write to req_addr=15 followed by a read of addr 15 returns the written data, and that addr 0 is unaffected.
